ddr_lane_dly_ctrl: RTL and testbench

Sequencer for one DDR4 lane's IOD delay line, sitting directly upstream of the lane IOD wrapper's DELAY_LINE_MOVE_0 / DELAY_LINE_DIRECTION_0 / DELAY_LINE_LOAD_0 / DELAY_LINE_OUT_OF_RANGE_0 pins. It accepts load, relative and absolute tap commands from the training logic over a valid/ready handshake. It expands each command into correctly spaced single-step MOVE pulses, tracks the current tap position, and flags range errors.

---
 rtl/ddr_lane_dly_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ddr_lane_dly_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ddr_lane_dly_ctrl.sv
// Delay-line sequencer for one DDR4 lane IOD: expands load/relative/absolute tap
// commands into spaced single-step MOVE pulses while tracking the tap position.
module ddr_lane_dly_ctrl #(
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 127,
  parameter int LOAD_TAP   = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic             FAB_CLK,
  input  logic             SYNC_RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [TAP_W-1:0] CMD_STEPS,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] TAP_POS,
  output logic             POS_VALID,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  output logic             DELAY_LINE_LOAD_0,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TAP_W:0]   MAX_X       = (TAP_W+1)'(MAX_TAP);
  localparam logic [TAP_W:0]   STEP_ONE    = (TAP_W+1)'(1);
  localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_MOVE, S_SETTLE, S_LOADP, S_FIN
  } state_t;

  state_t           state_q;
  logic             ready_q, done_q, err_q, pv_q, move_q, load_q, dir_q, oor_q;
  logic [TAP_W-1:0] tap_q;
  logic [TAP_W:0]   steps_q;
  logic [CNT_W-1:0] settle_q;
  logic [1:0]       op_q;

  logic [TAP_W:0] pos_x, req_x, target_x, n_d;
  logic           dir_d, clamp_d;

  function automatic logic [TAP_W:0] sat_min(input logic [TAP_W:0] a,
                                             input logic [TAP_W:0] lim);
    return (a > lim) ? lim : a;
  endfunction

  // Effective step count is computed one bit wider so MAX_TAP - pos cannot wrap.
  always_comb begin
    pos_x    = {1'b0, tap_q};
    req_x    = {1'b0, CMD_STEPS};
    target_x = sat_min(req_x, MAX_X);
    n_d      = '0;
    dir_d    = dir_q;
    clamp_d  = 1'b0;
    case (CMD_OP)
      2'b01: begin
        n_d     = sat_min(req_x, MAX_X - pos_x);
        dir_d   = 1'b1;
        clamp_d = req_x > (MAX_X - pos_x);
      end
      2'b10: begin
        n_d     = sat_min(req_x, pos_x);
        dir_d   = 1'b0;
        clamp_d = req_x > pos_x;
      end
      2'b11: begin
        clamp_d = req_x > MAX_X;
        if (target_x > pos_x) begin
          n_d   = target_x - pos_x;
          dir_d = 1'b1;
        end else begin
          n_d   = pos_x - target_x;
          dir_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tap_q   <= '0;
      pv_q    <= 1'b0;
      move_q  <= 1'b0;
      load_q  <= 1'b0;
      dir_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (CMD_VALID) begin
            ready_q <= 1'b0;
            oor_q   <= 1'b0;
            op_q    <= CMD_OP;
            if (CMD_OP == 2'b00) begin
              err_q   <= 1'b0;
              load_q  <= 1'b1;
              state_q <= S_LOADP;
            end else if (!pv_q) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else if (n_d == '0) begin
              err_q   <= clamp_d;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              err_q   <= clamp_d;
              dir_q   <= dir_d;
              steps_q <= n_d;
              state_q <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          move_q  <= 1'b1;
          state_q <= S_MOVE;
        end
        S_MOVE: begin
          move_q   <= 1'b0;
          tap_q    <= dir_q ? (tap_q + TAP_ONE) : (tap_q - TAP_ONE);
          steps_q  <= steps_q - STEP_ONE;
          settle_q <= '0;
          state_q  <= S_SETTLE;
        end
        S_LOADP: begin
          load_q   <= 1'b0;
          settle_q <= '0;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (DELAY_LINE_OUT_OF_RANGE_0) begin
            oor_q <= 1'b1;
            err_q <= 1'b1;
          end
          // An out-of-range flag anywhere in this settle window drops the remaining steps.
          if (settle_q == SETTLE_LAST) begin
            if (op_q == 2'b00) begin
              tap_q   <= TAP_W'(LOAD_TAP);
              pv_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else if ((steps_q != '0) && !oor_q && !DELAY_LINE_OUT_OF_RANGE_0) begin
              move_q  <= 1'b1;
              state_q <= S_MOVE;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end else begin
            settle_q <= settle_q + CNT_ONE;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CMD_READY              = ready_q;
  assign DONE                   = done_q;
  assign ERR                    = err_q;
  assign TAP_POS                = tap_q;
  assign POS_VALID              = pv_q;
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = dir_q;
  assign DELAY_LINE_LOAD_0      = load_q;

endmodule

// File: tb/tb_ddr_lane_dly_ctrl.sv
// Bench for ddr_lane_dly_ctrl: directed and random commands against a
// target-position model of the delay line.
module tb_ddr_lane_dly_ctrl;
  localparam int TAP_W = 8, MAX_TAP = 127, LOAD_TAP = 1, SETTLE_CYC = 4;
  localparam int PER = SETTLE_CYC + 1;

  logic clk = 1'b0;
  logic rst, cmd_valid, oor;
  logic [1:0] cmd_op;
  logic [TAP_W-1:0] cmd_steps;
  wire cmd_ready, done, err, pos_valid, mv, dir, ld;
  wire [TAP_W-1:0] tap_pos;

  int checks = 0, failures = 0;
  int m_pos = 0;
  bit m_pv = 1'b0, m_dir = 1'b0;

  always #5 clk = ~clk;

  ddr_lane_dly_ctrl #(.TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .LOAD_TAP(LOAD_TAP),
                      .SETTLE_CYC(SETTLE_CYC)) dut (
    .FAB_CLK(clk), .SYNC_RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_OP(cmd_op), .CMD_STEPS(cmd_steps), .DONE(done), .ERR(err),
    .TAP_POS(tap_pos), .POS_VALID(pos_valid), .DELAY_LINE_MOVE_0(mv),
    .DELAY_LINE_DIRECTION_0(dir), .DELAY_LINE_LOAD_0(ld),
    .DELAY_LINE_OUT_OF_RANGE_0(oor));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_tap"}, tap_pos, 0);
    chk({tag, "_pv"}, pos_valid, 0);
    chk({tag, "_move"}, mv, 0);
    chk({tag, "_load"}, ld, 0);
    chk({tag, "_dir"}, dir, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; oor = 1'b0;
    @(negedge clk);
    check_reset_vals(tag);
    rst = 1'b0;
    m_pos = 0; m_pv = 1'b0; m_dir = 1'b0;
  endtask

  // Model works from the requested final position, not from step counts.
  task automatic run_cmd(input int op, input int steps, input int oor_cyc, input string tag);
    int want, exp_final, exp_n, exp_issued, exp_done;
    bit exp_err, exp_dir, exp_mv, exp_ld, prev_pulse;
    int done_cyc, n_moves, bad_moves, bad_loads, bad_dir, bad_pulse;
    logic [31:0] tap_at, err_at, pv_at;
    done_cyc = -1; n_moves = 0; bad_moves = 0; bad_loads = 0; bad_dir = 0; bad_pulse = 0;
    prev_pulse = 1'b0; tap_at = 'x; err_at = 'x; pv_at = 'x;
    exp_issued = 0; exp_dir = m_dir;
    if (op == 0) begin
      exp_done = 2 + SETTLE_CYC;
      exp_final = LOAD_TAP;
      exp_err = (oor_cyc >= 2) && (oor_cyc <= 1 + SETTLE_CYC);
    end else if (!m_pv) begin
      exp_done = 1; exp_final = m_pos; exp_err = 1'b1;
    end else begin
      case (op)
        1: want = m_pos + steps;
        2: want = m_pos - steps;
        default: want = steps;
      endcase
      exp_final = (want > MAX_TAP) ? MAX_TAP : ((want < 0) ? 0 : want);
      exp_err = (want != exp_final);
      exp_n = (exp_final > m_pos) ? exp_final - m_pos : m_pos - exp_final;
      if (exp_n > 0) exp_dir = (exp_final > m_pos);
      exp_issued = exp_n;
      for (int k = 0; k < exp_n; k++)
        if (exp_issued == exp_n && oor_cyc >= 3 + k*PER && oor_cyc <= 2 + k*PER + SETTLE_CYC) begin
          exp_issued = k + 1;
          exp_err = 1'b1;
        end
      exp_done = (exp_n == 0) ? 1 : 2 + exp_issued*PER;
      exp_final = exp_dir ? m_pos + exp_issued : m_pos - exp_issued;
    end

    @(negedge clk);
    chk({tag, "_ready_pre"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_steps = TAP_W'(steps);
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_steps = TAP_W'($urandom);
    for (int c = 1; c <= 1000 && done_cyc < 0; c++) begin
      @(negedge clk);
      oor = (c == oor_cyc);
      exp_mv = (op != 0) && (c >= 2) && ((c - 2) % PER == 0) && ((c - 2) / PER < exp_issued);
      exp_ld = (op == 0) && (c == 1);
      if (mv) n_moves++;
      if (mv !== exp_mv) bad_moves++;
      if (ld !== exp_ld) bad_loads++;
      if (dir !== exp_dir) bad_dir++;
      if ((mv && ld) || ((mv || ld) && prev_pulse)) bad_pulse++;
      prev_pulse = mv || ld;
      if (done === 1'b1) begin
        done_cyc = c; tap_at = tap_pos; err_at = err; pv_at = pos_valid;
      end
    end
    oor = 1'b0;
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_move_count"}, n_moves, exp_issued);
    chk({tag, "_move_timing"}, bad_moves, 0);
    chk({tag, "_load_timing"}, bad_loads, 0);
    chk({tag, "_dir"}, bad_dir, 0);
    chk({tag, "_pulse_rules"}, bad_pulse, 0);
    chk({tag, "_tap"}, tap_at, exp_final);
    chk({tag, "_err"}, err_at, exp_err);
    chk({tag, "_pv"}, pv_at, (op == 0) ? 1 : m_pv);
    @(negedge clk);
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_ready_post"}, cmd_ready, 1);
    chk({tag, "_err_held"}, err, exp_err);
    m_pos = exp_final;
    if (op == 0) m_pv = 1'b1;
    m_dir = exp_dir;
  endtask

  task automatic reset_mid_move();
    int pulses;
    pulses = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_steps = 5;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("rstmid_move_before", mv, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rstmid");
    @(negedge clk);
    if (mv || ld) pulses++;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mv || ld) pulses++;
    end
    chk("rstmid_no_pulses", pulses, 0);
    chk("rstmid_ready", cmd_ready, 1);
    chk("rstmid_tap", tap_pos, 0);
    m_pos = 0; m_pv = 1'b0; m_dir = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, steps, oc;
    rst = 1'b1; cmd_valid = 1'b0; oor = 1'b0; cmd_op = 2'b00; cmd_steps = '0;
    do_reset("reset");
    run_cmd(1, 3, -1, "inc_nopv");
    run_cmd(0, 0, -1, "load");
    run_cmd(1, 3, -1, "inc3");
    run_cmd(3, 2, -1, "abs2");
    run_cmd(3, 2, -1, "abs2_again");
    run_cmd(1, 200, -1, "inc200");
    run_cmd(2, 5, 9, "dec5_oor");
    run_cmd(3, 250, -1, "abs_clamp");
    run_cmd(0, 0, 3, "load_oor");
    run_cmd(2, 9, -1, "dec_floor");
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      steps = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      oc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : -1;
      run_cmd(op, steps, oc, $sformatf("rnd%0d", i));
    end
    do_reset("reset2");
    run_cmd(2, 4, -1, "dec_nopv");
    run_cmd(3, 9, -1, "abs_nopv");
    run_cmd(0, 0, -1, "load2");
    reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
